rpi_irq_clk_gen: RTL and testbench



---
 rtl/rpi_irq_clk_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_rpi_irq_clk_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpi_irq_clk_gen.sv
// ---------------------------------------------------------------------------
// rpi_irq_clk_gen
//
// Multi-channel interrupt clock generator for the Raspberry Pi interrupt GPIO.
// Rising edges on the request lines are latched as pending bits. The
// lowest-index pending channel is signalled on clk_out, either as a single
// pulse of div+1 cycles or as a free-running clock of period 2*(div+1), until
// the Pi acknowledges. Every completed or abandoned request is followed by GAP
// cycles of forced-low clk_out.
//
// Optional feature macro: RPI_IRQ_TIMEOUT_EN
//   When defined, a request that sees no ack for TIMEOUT busy cycles is
//   abandoned with a one-cycle timeout strobe. Its pending bit stays set, so
//   the channel is signalled again after the gap. When undefined, timeout is
//   tied low and the block waits for ack indefinitely.
//
// Ports
//   clk_in   in   system clock; all logic runs on its rising edge
//   reset    in   synchronous, active-high reset
//   irq_req  in   [CHANNELS] level requests; a rising edge raises an interrupt
//   mode     in   0 = clock burst, 1 = single pulse (sampled when service starts)
//   div      in   [DIV_W] half-period / pulse length minus one (sampled when
//                 service starts)
//   ack      in   asynchronous acknowledge from the Pi, rising-edge sensitive
//   clk_out  out  registered interrupt line to the Pi
//   irq_id   out  [ID_W] channel being signalled; valid while busy
//   busy     out  high while a request is signalled or waiting for ack
//   pending  out  [CHANNELS] latched requests that are not yet acknowledged
//   timeout  out  one-cycle strobe when an ack wait expires
// ---------------------------------------------------------------------------
module rpi_irq_clk_gen #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 50000,
    parameter int ID_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] irq_req,
    input  logic                mode,
    input  logic [DIV_W-1:0]    div,
    input  logic                ack,
    output logic                clk_out,
    output logic [ID_W-1:0]     irq_id,
    output logic                busy,
    output logic [CHANNELS-1:0] pending,
    output logic                timeout
);

    // The gap counter counts GAP-1 down to 0, so GAP states are spent in ST_GAP.
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    // The ack-wait counter is 16 bits wide, so TIMEOUT must fit in it.
    if (CHANNELS < 1 || CHANNELS > 16 || GAP < 1 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_param_check
        $error("rpi_irq_clk_gen: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                mode_q, mode_d;
    logic                clk_out_q, clk_out_d;
    logic [ID_W-1:0]     irq_id_q, irq_id_d;
    logic [ID_W-1:0]     sel_id;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] req_prev_q;
    logic [CHANNELS-1:0] rise_mask;
    logic [CHANNELS-1:0] clr_mask;
    logic                ack_meta_q, ack_sync_q, ack_prev_q;
    logic                ack_rise;
    logic                clr_en;
    logic                tmo_hit;

    assign ack_rise = ack_sync_q & ~ack_prev_q;
    assign busy     = (state_q == ST_ACTIVE) || (state_q == ST_WAIT);

    // Per-channel edge detect and acknowledge clear.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign rise_mask[gi] = irq_req[gi] & ~req_prev_q[gi];
        assign clr_mask[gi]  = clr_en && (irq_id_q == ID_W'(gi));
    end

    // A new edge wins over a same-cycle acknowledge, so the channel stays
    // pending and is served again after the gap.
    assign pending_d = (pending_q & ~clr_mask) | rise_mask;

    // Fixed priority: the lowest-index pending channel is selected.
    always_comb begin
        sel_id = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        gap_cnt_d = gap_cnt_q;
        mode_d    = mode_q;
        clk_out_d = clk_out_q;
        irq_id_d  = irq_id_q;
        clr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    irq_id_d  = sel_id;
                    cnt_d     = div;
                    div_d     = div;
                    mode_d    = mode;
                    clk_out_d = 1'b1;
                    state_d   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ack_rise) begin
                    clr_en    = 1'b1;
                    clk_out_d = 1'b0;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (tmo_hit) begin
                    clk_out_d = 1'b0;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (cnt_q == '0) begin
                    if (mode_q) begin
                        clk_out_d = 1'b0;
                        state_d   = ST_WAIT;
                    end else begin
                        clk_out_d = ~clk_out_q;
                        cnt_d     = div_q;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_WAIT: begin
                clk_out_d = 1'b0;
                if (ack_rise) begin
                    clr_en    = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (tmo_hit) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                clk_out_d = 1'b0;
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                clk_out_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            gap_cnt_q  <= '0;
            mode_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            irq_id_q   <= '0;
            pending_q  <= '0;
            // Track the live request level through reset so a line held high
            // across reset release is not mistaken for a new edge.
            req_prev_q <= irq_req;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            gap_cnt_q  <= gap_cnt_d;
            mode_q     <= mode_d;
            clk_out_q  <= clk_out_d;
            irq_id_q   <= irq_id_d;
            pending_q  <= pending_d;
            req_prev_q <= irq_req;
            ack_meta_q <= ack;
            ack_sync_q <= ack_meta_q;
            ack_prev_q <= ack_sync_q;
        end
    end

`ifdef RPI_IRQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;

    // Counts busy cycles of the current service; idles at zero otherwise, so
    // it reads 0 in the first ACTIVE cycle.
    assign tmo_hit = busy && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = busy ? (tmo_cnt_q + 16'd1) : 16'd0;
        // An ack arriving on the expiry edge takes precedence.
        timeout_d = tmo_hit & ~ack_rise;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            tmo_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    assign clk_out = clk_out_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_rpi_irq_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_rpi_irq_clk_gen
//
// Self-checking bench for rpi_irq_clk_gen. A reference model follows the
// block's rules in terms of service start times and cycle arithmetic, and
// predicts outputs every cycle. Each predicted service start is queued; a
// monitor pops the queue when the DUT raises busy and compares the channel.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_rpi_irq_clk_gen;

    localparam int CHANNELS = 4;
    localparam int DIV_W    = 8;
    localparam int GAP      = 4;
    localparam int TIMEOUT  = 20;
    localparam int ID_W     = 2;
`ifdef RPI_IRQ_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic                clk_in = 1'b0;
    logic                reset  = 1'b1;
    logic [CHANNELS-1:0] irq_req = '0;
    logic                mode   = 1'b0;
    logic [DIV_W-1:0]    div    = '0;
    logic                ack    = 1'b0;
    logic                clk_out;
    logic [ID_W-1:0]     irq_id;
    logic                busy;
    logic [CHANNELS-1:0] pending;
    logic                timeout;

    rpi_irq_clk_gen #(
        .CHANNELS(CHANNELS),
        .DIV_W   (DIV_W),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .irq_req(irq_req),
        .mode   (mode),
        .div    (div),
        .ack    (ack),
        .clk_out(clk_out),
        .irq_id (irq_id),
        .busy   (busy),
        .pending(pending),
        .timeout(timeout)
    );

    always #10 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    typedef struct {
        int     ch;
        int     md;
        int     dv;
        longint t;
    } svc_t;
    svc_t exp_q[$];

    longint              cyc = 0;
    bit                  m_in_svc = 1'b0;
    longint              m_start = 0;
    int                  m_ch = 0;
    int                  m_mode = 0;
    int                  m_div = 0;
    int                  m_gap_left = 0;
    int                  m_last_id = 0;
    bit                  m_tmo = 1'b0;
    logic [CHANNELS-1:0] m_pend = '0;
    logic [CHANNELS-1:0] m_prev_req = '0;
    bit                  a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;  // ack samples 1/2/3 edges ago

    always @(posedge clk_in) begin
        bit                  rise_ack;
        bit                  expired;
        logic [CHANNELS-1:0] new_rise;
        svc_t                s;
        cyc++;
        if (reset) begin
            m_in_svc   = 1'b0;
            m_gap_left = 0;
            m_pend     = '0;
            m_last_id  = 0;
            m_tmo      = 1'b0;
            m_prev_req = irq_req;
            a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        end else begin
            rise_ack = a2 && !a3;
            new_rise = irq_req & ~m_prev_req;
            m_tmo    = 1'b0;
            if (m_in_svc) begin
                expired = TMO_ON && ((cyc - m_start) == TIMEOUT);
                if (rise_ack) m_pend[m_ch] = 1'b0;
                if (rise_ack || expired) begin
                    m_in_svc   = 1'b0;
                    m_gap_left = GAP;
                    m_tmo      = !rise_ack;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else if (m_pend != '0) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (m_pend[i]) begin
                        m_ch = i;
                        break;
                    end
                end
                m_in_svc  = 1'b1;
                m_start   = cyc;
                m_mode    = int'(mode);
                m_div     = int'(div);
                m_last_id = m_ch;
                s.ch = m_ch; s.md = m_mode; s.dv = m_div; s.t = cyc;
                exp_q.push_back(s);
            end
            m_pend     = m_pend | new_rise;
            m_prev_req = irq_req;
            a3 = a2; a2 = a1; a1 = ack;
        end
    end

    function automatic bit exp_clk();
        longint k;
        if (!m_in_svc) return 1'b0;
        k = cyc - m_start;
        if (m_mode == 1) return (k <= m_div);
        return ((k / (m_div + 1)) % 2) == 0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit busy_seen = 1'b0;

    always @(negedge clk_in) begin
        bit   e_clk;
        svc_t s;
        if (chk_en) begin
            e_clk = exp_clk();
            n_vec++;
            if ({clk_out, busy, pending, irq_id, timeout} !==
                {e_clk, m_in_svc, m_pend, ID_W'(m_last_id), m_tmo}) begin
                n_err++;
                if (n_err < 40)
                    $display("FAIL outputs @cycle %0d: clk_out/busy/pending/irq_id/timeout got %b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                             cyc, clk_out, busy, pending, irq_id, timeout,
                             e_clk, m_in_svc, m_pend, m_last_id, m_tmo);
            end
            if (busy === 1'b1 && !busy_seen) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL service_start @cycle %0d: DUT started channel %0d, required no service", cyc, irq_id);
                end else begin
                    s = exp_q.pop_front();
                    if (irq_id !== ID_W'(s.ch) || clk_out !== 1'b1) begin
                        n_err++;
                        $display("FAIL service_start @cycle %0d: irq_id/clk_out got %0d/%b required %0d/1",
                                 cyc, irq_id, clk_out, s.ch);
                    end else begin
                        $display("service ch=%0d mode=%0d div=%0d start_cycle=%0d", s.ch, s.md, s.dv, s.t);
                    end
                end
            end
            busy_seen = (busy === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_busy(input bit want, input int limit);
        n_vec++;
        for (int i = 0; i < limit; i++) begin
            if (busy === want) return;
            @(negedge clk_in);
        end
        n_err++;
        $display("FAIL wait_busy @cycle %0d: busy got %b required %b within %0d cycles", cyc, busy, want, limit);
    endtask

    task automatic pulse_ack(input int len);
        @(negedge clk_in);
        ack = 1'b1;
        repeat (len) @(negedge clk_in);
        ack = 1'b0;
    endtask

    initial begin
        @(negedge clk_in);
        chk_en = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);

        // Pulse mode on channel 2, div = 3.
        mode = 1'b1; div = 8'd3; irq_req = 4'b0100;
        wait_busy(1'b1, 10);
        repeat (7) @(negedge clk_in);
        pulse_ack(2);
        wait_busy(1'b0, 20);
        irq_req = '0;
        repeat (GAP + 3) @(negedge clk_in);

        // Two channels rising together, clock burst with div = 1.
        mode = 1'b0; div = 8'd1; irq_req = 4'b1010;
        wait_busy(1'b1, 10);
        repeat (8) @(negedge clk_in);
        pulse_ack(2);
        wait_busy(1'b0, 20);
        wait_busy(1'b1, 20);
        repeat (6) @(negedge clk_in);
        pulse_ack(2);
        wait_busy(1'b0, 20);
        irq_req = '0;
        repeat (GAP + 3) @(negedge clk_in);

        // New edge on channel 0 landing on the same edge as its ack_rise.
        mode = 1'b0; div = 8'd2; irq_req = 4'b0001;
        wait_busy(1'b1, 10);
        irq_req = '0;
        repeat (3) @(negedge clk_in);
        ack = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        irq_req[0] = 1'b1;
        @(negedge clk_in);
        ack = 1'b0;
        wait_busy(1'b0, 20);
        wait_busy(1'b1, 20);
        repeat (4) @(negedge clk_in);
        pulse_ack(2);
        wait_busy(1'b0, 20);
        irq_req = '0;
        repeat (GAP + 3) @(negedge clk_in);

        // Reset in mid-burst with requests held high across release.
        mode = 1'b0; div = 8'd5; irq_req = 4'b0010;
        wait_busy(1'b1, 10);
        repeat (4) @(negedge clk_in);
        reset = 1'b1; irq_req = 4'b0011;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (10) @(negedge clk_in);
        irq_req = '0;
        repeat (3) @(negedge clk_in);

        // Ack while idle is ignored; then div = 0 burst.
        pulse_ack(2);
        repeat (6) @(negedge clk_in);
        mode = 1'b0; div = 8'd0; irq_req = 4'b1000;
        wait_busy(1'b1, 10);
        repeat (7) @(negedge clk_in);
        pulse_ack(1);
        wait_busy(1'b0, 20);
        irq_req = '0;
        repeat (GAP + 3) @(negedge clk_in);

        // Long wait without ack (expires when the timeout feature is built in).
        mode = 1'b1; div = 8'd2; irq_req = 4'b0001;
        repeat (60) @(negedge clk_in);
        wait_busy(1'b1, 40);
        pulse_ack(2);
        irq_req = '0;
        repeat (GAP + 10) @(negedge clk_in);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_in);
            if ($urandom_range(0, 7) == 0) irq_req[$urandom_range(0, CHANNELS - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                mode = 1'($urandom_range(0, 1));
                div  = DIV_W'($urandom_range(0, 3));
            end
            if (ack) begin
                if ($urandom_range(0, 1) == 0) ack = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                ack = 1'b1;
            end
            reset = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk_in);
        reset = 1'b0; ack = 1'b0;
        repeat (4) @(negedge clk_in);

        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d predicted services never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
